conv_patch_scheduler: RTL
=========================

CONV_PATCH_SCHEDULER -- requirements
Module: conv_patch_scheduler

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning image width in pixel columns.
REQ-002 SHALL have parameter IMG_H, default 28, meaning image height in pixel rows.
REQ-003 SHALL have port clk  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous, active-high.
REQ-005 SHALL have port start  input  1  single-cycle pulse; begins an image scan when idle.
REQ-006 SHALL have port patch_size  input  3  window size; legal values 3, 5, 7; sampled at start.
REQ-007 SHALL have port hold  input  1  stall request from the clause consumer.
REQ-008 SHALL have port rd_en  output  1  image column read strobe.
REQ-009 SHALL have port rd_x  output  5  column index being read.
REQ-010 SHALL have port rd_y  output  5  row base being read.
REQ-011 SHALL have port rd_data  input  7  rows rd_y..rd_y+6 of column rd_x; valid one cycle after rd_en.
REQ-012 SHALL have port pixels  output  7  column slice to the convolution datapath.
REQ-013 SHALL have port pe_enable  output  1  shift strobe to the datapath.
REQ-014 SHALL have port conv_enable  output  1  window-compare strobe to the datapath.
REQ-015 SHALL have port win_x  output  5  x origin of the window compared this cycle.
REQ-016 SHALL have port win_y  output  5  y origin of the window compared this cycle.
REQ-017 SHALL have port busy  output  1  high from the cycle after an accepted start until done.
REQ-018 SHALL have port done  output  1  single-cycle pulse at scan completion.
REQ-019 SHALL have port err  output  1  single-cycle pulse when start is rejected.

Function
REQ-020 SHALL implement states IDLE, ROW, FLUSH, DONE; IDLE->ROW on start with legal patch_size; ROW->FLUSH after column IMG_W-1 is issued; FLUSH->ROW for the next row, or ->DONE after row IMG_H-P; DONE->IDLE after one cycle.
REQ-021 SHALL pulse err, stay IDLE and leave busy low when start arrives with patch_size not in {3,5,7}.
REQ-022 SHALL ignore start while busy.
REQ-023 SHALL, in ROW, issue rd_en with rd_x = 0..IMG_W-1 ascending and rd_y = current row base, one column per unstalled cycle.
REQ-024 SHALL drive pixels = registered rd_data with pe_enable = 1 exactly one cycle after each rd_en.
REQ-025 SHALL mask pixel bits at index >= P to 0.
REQ-026 SHALL, in FLUSH, issue one extra pe_enable cycle with pixels = 0 and no rd_en, so that the final window is compared.
REQ-027 SHALL number pe_enable cycles k = 0..IMG_W within a row and assert conv_enable only when P <= k <= IMG_W, giving IMG_W-P+1 windows per row.
REQ-028 SHALL drive win_x = k-P and win_y = row base whenever conv_enable is high; both SHALL be 0 otherwise.
REQ-029 SHALL step the row base by 1 (stride 1), from 0 to IMG_H-P inclusive.
REQ-030 SHALL pulse done exactly one cycle after the last FLUSH pe_enable, which has win_x = IMG_W-P and win_y = IMG_H-P.
REQ-031 SHALL make every column counter wrap to 0 at the end of a row, with no bubble beyond the FLUSH cycle.

Reset
REQ-032 SHALL, on rst, go to IDLE and drive rd_en, pe_enable, conv_enable, pixels, win_x, win_y, busy, done and err to 0, on the same edge.
REQ-033 SHALL let rst mid-scan abort the scan with no done pulse; a new start SHALL then be accepted on the next cycle after rst deasserts.

Configuration
REQ-034 SHALL, when CONV_SCHED_STALL_EN is defined, freeze rd_en, pe_enable, conv_enable, all counters and the state for each cycle that hold is high, and SHALL hold any read data already in flight until the stall is released.
REQ-035 SHALL, when CONV_SCHED_STALL_EN is undefined, ignore hold, so that the scan always runs at one column per cycle.

Verification
REQ-036 SHALL cover: P=3, IMG_W=IMG_H=28, no hold -> 26x26 = 676 conv_enable cycles, done after 26x29 pe_enable cycles, last window (25,25).
REQ-037 SHALL cover: P=7 -> 22 conv_enable cycles per row, with first win_x = 0 on k = 7 and rd_y values 0..21.
REQ-038 SHALL cover: start with patch_size=4 -> err pulses once, busy stays 0, no rd_en.
REQ-039 SHALL cover: rst asserted at row 5, column 10 -> all outputs 0 next cycle, no done; a restart completes normally.
REQ-040 SHALL cover: with CONV_SCHED_STALL_EN, hold high for 3 cycles mid-row -> the sequence of (win_x, win_y) is unchanged and the total duration grows by exactly 3 cycles.
REQ-041 SHALL cover: start pulsed while busy -> no effect on counters or on the done timing.

Source files
------------

// File: rtl/conv_patch_scheduler_if.sv
// Bus between the convolution patch scheduler, its image column store and its datapath.
// The slave modport is the scheduler's view. The master modport is the environment's view.
interface conv_patch_scheduler_if;
    logic       start;
    logic [2:0] patch_size;
    logic       hold;
    logic       rd_en;
    logic [4:0] rd_x;
    logic [4:0] rd_y;
    logic [6:0] rd_data;
    logic [6:0] pixels;
    logic       pe_enable;
    logic       conv_enable;
    logic [4:0] win_x;
    logic [4:0] win_y;
    logic       busy;
    logic       done;
    logic       err;

    modport slave (
        input  start, patch_size, hold, rd_data,
        output rd_en, rd_x, rd_y, pixels, pe_enable, conv_enable, win_x, win_y, busy, done, err
    );

    modport master (
        output start, patch_size, hold, rd_data,
        input  rd_en, rd_x, rd_y, pixels, pe_enable, conv_enable, win_x, win_y, busy, done, err
    );
endinterface

// File: rtl/conv_patch_scheduler.sv
// Scans an image column by column and emits P x P window compare strobes at stride 1.
// Define CONV_SCHED_STALL_EN to honour the consumer's hold input. Otherwise hold is ignored.
module conv_patch_scheduler #(
    parameter int unsigned IMG_W = 28,
    parameter int unsigned IMG_H = 28
) (
    input logic                   clk,
    input logic                   rst,
    conv_patch_scheduler_if.slave bus_io
);
    typedef enum logic [1:0] {StIdle, StRow, StFlush, StDone} state_e;

    localparam logic [4:0] LastCol = 5'(IMG_W - 1);
    localparam logic [4:0] FlushK  = 5'(IMG_W);
    localparam logic [4:0] ImgH    = 5'(IMG_H);

    state_e     state_q, state_d;
    logic [4:0] col_q, col_d;
    logic [4:0] row_q, row_d;
    logic [2:0] p_q, p_d;
    logic       pe_q, pe_d;
    logic       flush_q, flush_d;
    logic [4:0] k_q, k_d;
    logic [4:0] prow_q, prow_d;
    logic       done_q, done_d;
    logic       err_q, err_d;

    logic       stall;
    logic       legal;
    logic       last_row;
    logic       rd_en;
    logic       pe_out;
    logic       conv;
    logic [6:0] mask;
    logic [6:0] src;

`ifdef CONV_SCHED_STALL_EN
    // Column data lands one cycle after rd_en. If a stall hits that cycle, it is parked here.
    logic [6:0] skid_q, skid_d;
    logic       skid_v_q, skid_v_d;

    assign stall = bus_io.hold;
    assign src   = skid_v_q ? skid_q : bus_io.rd_data;

    always_comb begin
        skid_d   = skid_q;
        skid_v_d = skid_v_q;
        if (stall) begin
            if (pe_q && !flush_q && !skid_v_q) begin
                skid_d   = bus_io.rd_data;
                skid_v_d = 1'b1;
            end
        end else begin
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            skid_q   <= 7'd0;
            skid_v_q <= 1'b0;
        end else begin
            skid_q   <= skid_d;
            skid_v_q <= skid_v_d;
        end
    end
`else
    logic unused_hold;
    assign unused_hold = bus_io.hold;
    assign stall       = 1'b0;
    assign src         = bus_io.rd_data;
`endif

    assign legal    = (bus_io.patch_size == 3'd3) || (bus_io.patch_size == 3'd5) ||
                      (bus_io.patch_size == 3'd7);
    assign last_row = (row_q == ImgH - {2'b00, p_q});
    assign mask     = 7'h7f >> (3'd7 - p_q);

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        p_d     = p_q;
        pe_d    = pe_q;
        flush_d = flush_q;
        k_d     = k_q;
        prow_d  = prow_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        if (!stall) begin
            // The output stage follows the issue stage by one cycle.
            pe_d    = 1'b0;
            flush_d = 1'b0;
            k_d     = 5'd0;
            prow_d  = row_q;
            case (state_q)
                StIdle: begin
                    if (bus_io.start) begin
                        if (legal) begin
                            state_d = StRow;
                            p_d     = bus_io.patch_size;
                            col_d   = 5'd0;
                            row_d   = 5'd0;
                        end else begin
                            err_d = 1'b1;
                        end
                    end
                end
                StRow: begin
                    pe_d = 1'b1;
                    k_d  = col_q;
                    if (col_q == LastCol) begin
                        col_d   = 5'd0;
                        state_d = StFlush;
                    end else begin
                        col_d = col_q + 5'd1;
                    end
                end
                StFlush: begin
                    pe_d    = 1'b1;
                    flush_d = 1'b1;
                    k_d     = FlushK;
                    if (last_row) begin
                        state_d = StDone;
                    end else begin
                        row_d   = row_q + 5'd1;
                        state_d = StRow;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
                default: state_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            col_q   <= 5'd0;
            row_q   <= 5'd0;
            p_q     <= 3'd0;
            pe_q    <= 1'b0;
            flush_q <= 1'b0;
            k_q     <= 5'd0;
            prow_q  <= 5'd0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            p_q     <= p_d;
            pe_q    <= pe_d;
            flush_q <= flush_d;
            k_q     <= k_d;
            prow_q  <= prow_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign rd_en  = (state_q == StRow) && !stall;
    assign pe_out = pe_q && !stall;
    assign conv   = pe_out && (k_q >= {2'b00, p_q});

    assign bus_io.rd_en       = rd_en;
    assign bus_io.rd_x        = rd_en ? col_q : 5'd0;
    assign bus_io.rd_y        = rd_en ? row_q : 5'd0;
    assign bus_io.pe_enable   = pe_out;
    assign bus_io.pixels      = (pe_out && !flush_q) ? (src & mask) : 7'd0;
    assign bus_io.conv_enable = conv;
    assign bus_io.win_x       = conv ? (k_q - {2'b00, p_q}) : 5'd0;
    assign bus_io.win_y       = conv ? prow_q : 5'd0;
    assign bus_io.busy        = (state_q != StIdle);
    assign bus_io.done        = done_q;
    assign bus_io.err         = err_q;
endmodule
